traffic_light: RTL and testbench
================================

Name: traffic_light

Overview:
- Moore finite-state machine controlling a two-way intersection: a north-south (NS) main road and an east-west (EW) side road.
- NS holds green until a car is detected on EW. The controller then sequences NS yellow, EW green and EW yellow, and returns to NS green.
- Standalone leaf controller. It has one car-sensor input and a 6-bit lamp-drive output that goes straight to the lamp drivers.

Parameters:
- NS_MIN, default 1: minimum number of cycles GNS is held before a car request is honoured. Must be ≥1.
- Y_TIME, default 1: number of cycles in each yellow state (YNS, YEW). Must be ≥1.
- EW_TIME, default 1: number of cycles in GEW. Must be ≥1.
- TW, default 8: width of the dwell timer. Every duration must fit, i.e. ≤ 2^TW.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-low reset. A 0 sampled at a rising edge resets the block.
- carew, input, 1: EW car sensor. 1 means a car is waiting on EW. Level-sensitive, sampled at each rising edge.
- lights, output, 6: {ns[2:0], ew[2:0]}. Per-road one-hot encoding: 100 = green, 010 = yellow, 001 = red.

Behaviour:
- State register `state`, 2 bits, internal. Keep this exact name; the bench probes it hierarchically.
- State encodings: GNS=2'b00, YNS=2'b01, GEW=2'b11, YEW=2'b10.
- Timer `tmr` (TW bits) counts cycles remaining in the current state. It is loaded with duration−1 on every state entry and decrements each cycle it is nonzero.
- Reset: rst==0 at a rising edge sets state=GNS and tmr=NS_MIN−1. Reset has priority over every transition and may interrupt any state mid-dwell. Before the first reset, state is X; no power-up initialiser.
- Outputs are a pure combinational decode of `state` (Moore). They change only after clock edges. Zero latency from state to lights.
  - GNS: lights = 6'b100_001
  - YNS: lights = 6'b010_001
  - GEW: lights = 6'b001_100
  - YEW: lights = 6'b001_010
- Transitions are evaluated at the rising edge:
  - GNS → YNS when tmr==0 and carew==1. Otherwise stay in GNS.
  - If carew arrives while tmr>0, the request is not latched. carew must still be 1 once tmr reaches 0.
  - YNS → GEW when tmr==0. Load EW_TIME−1.
  - GEW → YEW when tmr==0. Load Y_TIME−1. carew is ignored in this state.
  - YEW → GNS when tmr==0. Load NS_MIN−1.
  - Entry into YNS loads Y_TIME−1.
- In all non-GNS states, carew is ignored; the cycle always completes.
- If carew is held high continuously, the FSM cycles forever: GNS for NS_MIN cycles, YNS for Y_TIME, GEW for EW_TIME, YEW for Y_TIME.
- With all parameters at default, each state lasts exactly one cycle when carew=1.
- A one-cycle carew pulse sampled in GNS with tmr==0 triggers one full cycle.
- An X on carew while in GNS may propagate X into state; no X-filtering is required.
- Safety invariant: the two roads are never both non-red at once. Exactly one road is red in every legal state.

Decomposition:
- Shared package `traffic_pkg` holds:
  - the state typedef (2-bit enum GNS/YNS/GEW/YEW);
  - lamp localparams GREEN=3'b100, YELLOW=3'b010, RED=3'b001.
- Single module. The lamp decode is a case statement; no sub-module is needed.

Test Plan:
- No reset for the first cycle → state and lights are X. Then drive rst=0 for one edge → state=00, lights=6'b100001 on the next cycle.
- Release reset with carew=0 for 3 cycles → state stays 00 and lights stay 100001.
- carew=1 for one cycle, then 0, with defaults → state sequence 01, 11, 10, 00 on consecutive cycles; lights 010001, 001100, 001010, 100001. Afterwards it stays in 00.
- carew held 1 for 8 cycles with defaults → repeating 00, 01, 11, 10. The check fires every cycle: never both ns≠001 and ew≠001.
- With NS_MIN=3, Y_TIME=2, EW_TIME=4 and carew held high → GNS 3 cycles, YNS 2, GEW 4, YEW 2, then repeats.
- Assert rst=0 while in GEW mid-dwell with EW_TIME=4 → next cycle state=00 and lights=100001, and the timer restarts from NS_MIN−1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and lamp codes for the two-way intersection controller.
package traffic_pkg;

    // Controller states; encodings are fixed so external probes can decode them.
    typedef enum logic [1:0] {
        GNS = 2'b00,
        YNS = 2'b01,
        GEW = 2'b11,
        YEW = 2'b10
    } state_t;

    // Per-road one-hot lamp codes.
    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

endpackage

// File: rtl/traffic_light.sv
// Moore controller for a NS main road / EW side road intersection.
// NS stays green until an EW car is seen after the NS minimum dwell, then the
// controller runs NS yellow, EW green, EW yellow and returns to NS green.
// The dwell timer holds cycles remaining in the current state; it is loaded
// with duration-1 on entry and counts down to zero, where it rests.
module traffic_light
    import traffic_pkg::*;
#(
    parameter int NS_MIN  = 1,
    parameter int Y_TIME  = 1,
    parameter int EW_TIME = 1,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       carew,
    output logic [5:0] lights
);

    localparam logic [TW-1:0] NS_LOAD = TW'(NS_MIN - 1);
    localparam logic [TW-1:0] Y_LOAD  = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] EW_LOAD = TW'(EW_TIME - 1);

    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   tmr;
    logic [TW-1:0]   tmr_d;

    // State and dwell timer registers; reset lands in NS green with a fresh NS dwell.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= GNS;
            tmr   <= NS_LOAD;
        end else begin
            state <= state_d;
            tmr   <= tmr_d;
        end
    end

    // Next-state and timer logic; a request in GNS is only honoured when the dwell has expired.
    always_comb begin
        state_d = state;
        tmr_d   = (tmr != '0) ? (tmr - TW'(1)) : tmr;
        case (state)
            GNS: begin
                if ((tmr == '0) && carew) begin
                    state_d = YNS;
                    tmr_d   = Y_LOAD;
                end
            end
            YNS: begin
                if (tmr == '0) begin
                    state_d = GEW;
                    tmr_d   = EW_LOAD;
                end
            end
            GEW: begin
                if (tmr == '0) begin
                    state_d = YEW;
                    tmr_d   = Y_LOAD;
                end
            end
            YEW: begin
                if (tmr == '0) begin
                    state_d = GNS;
                    tmr_d   = NS_LOAD;
                end
            end
            default: begin
                state_d = state;
            end
        endcase
    end

    // Lamp decode straight from state; exactly one road is red in every legal state.
    always_comb begin
        lights = {RED, RED};
        case (state)
            GNS:     lights = {GREEN,  RED};
            YNS:     lights = {YELLOW, RED};
            GEW:     lights = {RED,    GREEN};
            YEW:     lights = {RED,    YELLOW};
            default: lights = {RED,    RED};
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: one instance with default timing, one with
// NS_MIN=3, Y_TIME=2, EW_TIME=4.
module tb_traffic_light;

    logic       clk;
    logic       rst_a, carew_a;
    logic       rst_b, carew_b;
    logic [5:0] lights_a, lights_b;

    int checks;
    int passes;

    // {state, lights} expected after the next rising edge
    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       carew;
        logic [1:0] st;
    } vec_t;

    vec_t va[$];

    traffic_light u_a (
        .clk    (clk),
        .rst    (rst_a),
        .carew  (carew_a),
        .lights (lights_a)
    );

    traffic_light #(
        .NS_MIN  (3),
        .Y_TIME  (2),
        .EW_TIME (4),
        .TW      (8)
    ) u_b (
        .clk    (clk),
        .rst    (rst_b),
        .carew  (carew_b),
        .lights (lights_b)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lights_of(input logic [1:0] s);
        case (s)
            2'b00:   return 6'b100_001;
            2'b01:   return 6'b010_001;
            2'b11:   return 6'b001_100;
            default: return 6'b001_010;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // driver + scoreboard: push expectation, drive, clock, pop and compare
    task automatic step(input int sel, input logic r, input logic c,
                        input logic [1:0] es, input string name);
        logic [7:0] e;
        logic [1:0] st;
        logic [5:0] lt;
        exp_q.push_back({es, lights_of(es)});
        if (sel == 0) begin rst_a = r; carew_a = c; end
        else          begin rst_b = r; carew_b = c; end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (sel == 0) begin st = u_a.state; lt = lights_a; end
        else          begin st = u_b.state; lt = lights_b; end
        chk({name, ".state"},  {6'b0, st}, {6'b0, e[7:6]});
        chk({name, ".lights"}, {2'b0, lt}, {2'b0, e[5:0]});
        chk({name, ".safety"}, {7'b0, (lt[5:3] != 3'b001) && (lt[2:0] != 3'b001)}, 8'd0);
    endtask

    int dur[4];
    logic [1:0] sts[4];

    initial begin
        checks  = 0;
        passes  = 0;
        rst_a   = 1'b1;
        carew_a = 1'b0;
        rst_b   = 1'b1;
        carew_b = 1'b0;
        @(posedge clk);
        #1;

        // default-timing table: reset, idle, single pulse, then carew held
        va.push_back('{1'b0, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b1, 2'b01});
        va.push_back('{1'b1, 1'b0, 2'b11});
        va.push_back('{1'b1, 1'b0, 2'b10});
        va.push_back('{1'b1, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b0, 2'b00});
        va.push_back('{1'b1, 1'b0, 2'b00});
        for (int k = 0; k < 2; k++) begin
            va.push_back('{1'b1, 1'b1, 2'b01});
            va.push_back('{1'b1, 1'b1, 2'b11});
            va.push_back('{1'b1, 1'b1, 2'b10});
            va.push_back('{1'b1, 1'b1, 2'b00});
        end
        // carew held through EW phases is ignored there; one more pulse mid-GEW
        va.push_back('{1'b1, 1'b1, 2'b01});
        va.push_back('{1'b1, 1'b0, 2'b11});
        va.push_back('{1'b1, 1'b1, 2'b10});
        va.push_back('{1'b1, 1'b0, 2'b00});
        for (int i = 0; i < va.size(); i++)
            step(0, va[i].rst, va[i].carew, va[i].st, $sformatf("dflt[%0d]", i));

        // long timing with carew held: GNS 3, YNS 2, GEW 4, YEW 2, repeating
        dur[0] = 3; dur[1] = 2; dur[2] = 4; dur[3] = 2;
        sts[0] = 2'b00; sts[1] = 2'b01; sts[2] = 2'b11; sts[3] = 2'b10;
        step(1, 1'b0, 1'b1, 2'b00, "long.rst");
        for (int p = 0; p < 2; p++)
            for (int ph = 0; ph < 4; ph++)
                for (int k = ((p == 0 && ph == 0) ? 1 : 0); k < dur[ph]; k++)
                    step(1, 1'b1, 1'b1, sts[ph], $sformatf("long[%0d.%0d.%0d]", p, ph, k));

        // request while dwell nonzero is not latched
        step(1, 1'b0, 1'b0, 2'b00, "nolatch.rst");
        chk("nolatch.tmr", u_b.tmr, 8'd2);
        step(1, 1'b1, 1'b1, 2'b00, "nolatch.early");
        for (int k = 0; k < 3; k++)
            step(1, 1'b1, 1'b0, 2'b00, $sformatf("nolatch.idle%0d", k));
        step(1, 1'b1, 1'b1, 2'b01, "nolatch.go");

        // reset mid-dwell in GEW restarts NS dwell
        step(1, 1'b1, 1'b0, 2'b01, "mid.yns");
        step(1, 1'b1, 1'b0, 2'b11, "mid.gew0");
        step(1, 1'b1, 1'b0, 2'b11, "mid.gew1");
        step(1, 1'b0, 1'b1, 2'b00, "mid.rst");
        chk("mid.tmr", u_b.tmr, 8'd2);
        step(1, 1'b1, 1'b1, 2'b00, "mid.g1");
        step(1, 1'b1, 1'b1, 2'b00, "mid.g2");
        step(1, 1'b1, 1'b1, 2'b01, "mid.yns2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
